// File: rtl/fir_interp_pkg.sv
// rtl/fir_interp_pkg.sv - shared types, defaults and coefficients for the FIR interpolator
// Purpose: FSM state enum, default filter geometry and the 48-tap prototype filter.
// Ports: none (package).
package fir_interp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_e;

   localparam int DEFAULT_TAPS  = 48;
   localparam int DEFAULT_L     = 4;
   localparam int DEFAULT_SHIFT = 8;

   // Hann-windowed sinc, cutoff fs_in/2, symmetric (h[k] == h[47-k]).
   // Each polyphase branch sums to 257..259, i.e. unity gain after >>8.
   localparam logic signed [15:0] INTERP_COEFFS [0:47] = '{
      16'sd1,    16'sd0,    16'sd0,    16'sd0,
      16'sd1,    16'sd2,    16'sd3,    16'sd2,
      -16'sd2,   -16'sd7,   -16'sd9,   -16'sd5,
      16'sd6,    16'sd17,   16'sd21,   16'sd11,
      -16'sd13,  -16'sd38,  -16'sd48,  -16'sd25,
      16'sd34,   16'sd117,  16'sd199,  16'sd249,
      16'sd249,  16'sd199,  16'sd117,  16'sd34,
      -16'sd25,  -16'sd48,  -16'sd38,  -16'sd13,
      16'sd11,   16'sd21,   16'sd17,   16'sd6,
      -16'sd5,   -16'sd9,   -16'sd7,   -16'sd2,
      16'sd2,    16'sd3,    16'sd2,    16'sd1,
      16'sd0,    16'sd0,    16'sd0,    16'sd1
   };

endpackage

// File: rtl/fir_interpolator_if.sv
// rtl/fir_interpolator_if.sv - sample-in / sample-out handshake bundle for the FIR interpolator
// Purpose: groups the input (s_*) and output (m_*) valid/ready streams.
// Signals:
//   s_valid, s_data  - input sample offered by the producer
//   s_ready          - interpolator can accept an input sample
//   m_valid, m_data  - filtered output sample
//   m_ready          - consumer accepts the output sample
// Modports: master = producer/consumer side, slave = interpolator side.
interface fir_interpolator_if;

   logic               s_valid;
   logic               s_ready;
   logic signed [31:0] s_data;
   logic               m_valid;
   logic               m_ready;
   logic signed [31:0] m_data;

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data
   );

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data
   );

endinterface

// File: rtl/fir_interp_coef_rom.sv
// rtl/fir_interp_coef_rom.sv - combinational polyphase coefficient lookup h[j*L+phase]
// Purpose: selects the prototype tap used by branch tap j of polyphase branch phase.
// Ports:
//   j_i     - tap index within the polyphase branch
//   phase_i - output phase (0..L-1)
//   coef_o  - signed 16-bit coefficient
module fir_interp_coef_rom
   import fir_interp_pkg::*;
#(
   parameter int L  = DEFAULT_L,
   parameter int JW = 4,
   parameter int PW = 2
) (
   input  logic [JW-1:0]      j_i,
   input  logic [PW-1:0]      phase_i,
   output logic signed [15:0] coef_o
);

   localparam int IW = $clog2(DEFAULT_TAPS);

   logic [IW-1:0] idx;

   assign idx    = IW'(j_i) * IW'(L) + IW'(phase_i);
   assign coef_o = INTERP_COEFFS[idx];

endmodule

// File: rtl/fir_interpolator.sv
// rtl/fir_interpolator.sv - polyphase FIR interpolator built around one time-multiplexed MAC
// Purpose: accepts one sample, then produces L filtered outputs, one MAC per cycle.
// Ports:
//   clk - clock, all state on the rising edge
//   rst - asynchronous active-high reset
//   bus - fir_interpolator_if.slave: s_valid/s_data/s_ready in, m_valid/m_data/m_ready out
module fir_interpolator
   import fir_interp_pkg::*;
#(
   parameter int TAPS  = DEFAULT_TAPS,
   parameter int L     = DEFAULT_L,
   parameter int SHIFT = DEFAULT_SHIFT
) (
   input  logic              clk,
   input  logic              rst,
   fir_interpolator_if.slave bus
);

   localparam int P  = TAPS / L;
   localparam int JW = (P > 1) ? $clog2(P) : 1;
   localparam int PW = (L > 1) ? $clog2(L) : 1;

   state_e             state_q, state_d;
   logic [PW-1:0]      phase_q, phase_d;
   logic [JW-1:0]      j_q, j_d;
   logic signed [47:0] acc_q, acc_d;
   logic               m_valid_q, m_valid_d;
   logic signed [31:0] m_data_q, m_data_d;
   logic signed [31:0] dl_q [P];
   logic               shift_en;

   logic signed [15:0] coef;
   logic signed [47:0] prod;
   logic signed [47:0] acc_sum;

   fir_interp_coef_rom #(
      .L  (L),
      .JW (JW),
      .PW (PW)
   ) u_coef_rom (
      .j_i     (j_q),
      .phase_i (phase_q),
      .coef_o  (coef)
   );

   // Both operands are sign-extended to 48 bits so the product is exact.
   assign prod    = 48'(coef) * 48'(dl_q[j_q]);
   assign acc_sum = acc_q + prod;

   assign bus.s_ready = (state_q == IDLE);
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      j_d       = j_q;
      acc_d     = acc_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      shift_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.s_valid) begin
               shift_en = 1'b1;
               phase_d  = '0;
               j_d      = '0;
               acc_d    = '0;
               state_d  = MAC;
            end
         end
         MAC: begin
            acc_d = acc_sum;
            if (j_q == JW'(P - 1)) begin
               // Output taken from the sum that already includes the last product.
               m_data_d  = acc_sum[SHIFT+31:SHIFT];
               m_valid_d = 1'b1;
               state_d   = OUT;
            end else begin
               j_d = j_q + JW'(1);
            end
         end
         OUT: begin
            if (bus.m_ready) begin
               m_valid_d = 1'b0;
               if (phase_q == PW'(L - 1)) begin
                  state_d = IDLE;
               end else begin
                  phase_d = phase_q + PW'(1);
                  j_d     = '0;
                  acc_d   = '0;
                  state_d = MAC;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         j_q       <= '0;
         acc_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         j_q       <= j_d;
         acc_q     <= acc_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
      end
   end

   // dl_q[0] is the newest sample; the oldest falls off the end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < P; i++) dl_q[i] <= '0;
      end else if (shift_en) begin
         dl_q[0] <= bus.s_data;
         for (int i = 1; i < P; i++) dl_q[i] <= dl_q[i-1];
      end
   end

endmodule

// File: tb/tb_fir_interpolator.sv
// tb/tb_fir_interpolator.sv - directed self-checking bench for fir_interpolator
module tb_fir_interpolator;

   logic clk = 1'b0;
   logic rst;

   fir_interpolator_if bus ();

   fir_interpolator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Independent copy of the prototype filter taps.
   int h_ref [0:47] = '{
        1,   0,   0,   0,   1,   2,   3,   2,  -2,  -7,  -9,  -5,
        6,  17,  21,  11, -13, -38, -48, -25,  34, 117, 199, 249,
      249, 199, 117,  34, -25, -48, -38, -13,  11,  21,  17,   6,
       -5,  -9,  -7,  -2,   2,   3,   2,   1,   0,   0,   0,   1
   };

   // Hand-summed polyphase branch gains (steady-state output for input 256).
   int dc_ref [0:3] = '{259, 257, 257, 259};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Offer one sample; returns at the negedge after the accepting edge.
   task automatic push(input logic signed [31:0] val);
      int cnt;
      cnt = 0;
      @(negedge clk);
      while (!bus.s_ready && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (!bus.s_ready) check("push_timeout", bus.s_ready, 1);
      bus.s_valid = 1'b1;
      bus.s_data  = val;
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.m_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.m_valid) check("valid_timeout", bus.m_valid, 1);
   endtask

   // Wait for an output, sample it, and let the handshake edge pass (m_ready assumed high).
   task automatic pop(output logic signed [31:0] d, output int lat);
      wait_valid(lat);
      d = bus.m_data;
      @(negedge clk);
   endtask

   task automatic run_impulse(input string pfx);
      logic signed [31:0] d;
      int lat;
      int k;
      for (int n = 0; n < 13; n++) begin
         push((n == 0) ? 32'sd256 : 32'sd0);
         for (int p = 0; p < 4; p++) begin
            pop(d, lat);
            k = n * 4 + p;
            if (k == 0) check({pfx, "_latency"}, lat, 12);
            if (k == 1) check({pfx, "_spacing"}, lat + 1, 13);
            check($sformatf("%s_k%0d", pfx, k), d, (k < 48) ? h_ref[k] : 0);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [31:0] d;
      logic signed [31:0] d0;
      int lat;

      rst         = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;
      #12;
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_m_data", bus.m_data, 0);
      check("rst_s_ready", bus.s_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      // Impulse response, m_ready tied high
      bus.m_ready = 1'b1;
      run_impulse("imp");

      // DC gain per phase
      do_reset();
      for (int n = 0; n < 14; n++) begin
         push(32'sd256);
         for (int p = 0; p < 4; p++) begin
            pop(d, lat);
            if (n >= 11) check($sformatf("dc_n%0d_p%0d", n, p), d, dc_ref[p]);
         end
      end

      // Backpressure held for 10 cycles in OUT
      do_reset();
      bus.m_ready = 1'b0;
      push(32'sd256);
      wait_valid(lat);
      check("bp_latency", lat, 12);
      d0 = bus.m_data;
      check("bp_phase0", d0, h_ref[0]);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("bp_valid_c%0d", c), bus.m_valid, 1);
         check($sformatf("bp_data_c%0d", c), bus.m_data, d0);
         check($sformatf("bp_sready_c%0d", c), bus.s_ready, 0);
      end
      bus.m_ready = 1'b1;
      @(negedge clk);
      pop(d, lat);
      check("bp_release_gap", lat + 1, 13);
      check("bp_phase1", d, h_ref[1]);
      pop(d, lat);
      pop(d, lat);

      // Sign handling and floor behaviour of the arithmetic shift
      do_reset();
      push(-32'sd1);
      pop(d, lat);
      check("floor_m1_p0", d, -1);
      pop(d, lat);
      check("floor_m1_p1", d, 0);
      pop(d, lat);
      pop(d, lat);
      do_reset();
      push(-32'sd256);
      pop(d, lat);
      check("floor_m256_p0", d, -1);
      pop(d, lat);
      pop(d, lat);
      pop(d, lat);
      do_reset();
      push(-32'sd300);
      pop(d, lat);
      check("floor_m300_p0", d, -2);
      pop(d, lat);
      pop(d, lat);
      pop(d, lat);

      // Asynchronous reset while an output is held in OUT
      do_reset();
      bus.m_ready = 1'b0;
      push(32'sd1000);
      wait_valid(lat);
      check("pre_rst_data", bus.m_data, 3);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_m_valid", bus.m_valid, 0);
      check("async_rst_m_data", bus.m_data, 0);
      check("async_rst_s_ready", bus.s_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      // Reset during the MAC of phase 2, then a clean impulse run
      bus.m_ready = 1'b1;
      push(32'sd1000);
      pop(d, lat);
      pop(d, lat);
      repeat (3) @(negedge clk);
      check("mac_s_ready_busy", bus.s_ready, 0);
      rst = 1'b1;
      #1;
      check("mac_rst_s_ready", bus.s_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      run_impulse("imp2");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fir_interpolator.md
# fir_interpolator

Polyphase FIR interpolator on the output side of the sample datapath: accepts one 32-bit signed sample per handshake and emits L filtered output samples at L× rate. Mirrors the decimating front-end filter. It uses a single time-multiplexed MAC instead of a full parallel tap array, with valid/ready handshakes on both sides. Coefficients come from a 16-bit signed ROM; the result is rescaled by an arithmetic right shift.

## Interface
- `TAPS`, 48: prototype filter length; must be a multiple of `L`.
- `L`, 4: interpolation factor.
- `SHIFT`, 8: right-shift applied to the 48-bit accumulator.
- `P`, `TAPS/L` (derived localparam, 12): taps per polyphase branch.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `s_valid` input 1: input sample valid.
- `s_ready` output 1: block can accept an input sample.
- `s_data` input 32: signed input sample.
- `m_valid` output 1: output sample valid.
- `m_ready` input 1: downstream accepts output.
- `m_data` output 32: signed output sample.

## Operation
- Delay line: `P` × 32-bit signed registers `dl[0..P-1]`, where `dl[0]` is the newest sample.
- Output for input n, phase p (0..L-1): `y = sum_{j=0..P-1} h[j*L+p] * dl[j]`.
- Accumulator: 48-bit signed. Products are 32×16 signed, sign-extended to 48 bits. Wrap on overflow, no saturation.
- `m_data` = `acc[SHIFT+31:SHIFT]`: arithmetic shift, which floors toward −inf. Upper bits are discarded (wrap).
- FSM states: IDLE, MAC, OUT.
  - IDLE: `s_ready`=1. On `s_valid`: shift `s_data` into `dl[0]` (older samples move up, `dl[P-1]` is dropped). Clear `phase` to 0, `j` to 0, `acc` to 0, then go to MAC.
  - MAC: one product per cycle, `acc += h[j*L+phase]*dl[j]`, then `j++`. On `j==P-1`, load `m_data` from the final sum (including that product), set `m_valid`=1, go to OUT.
  - OUT: hold `m_data` and `m_valid` until `m_ready`. On handshake:
    - if `phase==L-1`: clear `m_valid`, go to IDLE;
    - else: `phase++`, `j`=0, `acc`=0, clear `m_valid`, go to MAC.
- `s_ready` is a combinational decode of state==IDLE. It is low in MAC and OUT.
- `s_valid` outside IDLE is ignored; no sample is consumed.

## Timing
- Reset values (asynchronous):
  - state=IDLE, `phase`=0, `j`=0, `acc`=0, all `dl`=0;
  - `m_valid`=0, `m_data`=0, `s_ready`=1.
- Latency: `m_valid` rises `P` cycles after the input-acceptance edge (12 at defaults).
- Per phase: `P` MAC cycles + ≥1 OUT cycle.
- With `m_ready` tied high, one input occupies `1 + L*(P+1)` = 53 cycles. Outputs are spaced `P+1` = 13 cycles apart.
- Backpressure: while `m_valid && !m_ready`, `m_data` is stable and no state advances.
- `m_ready` asserted while `m_valid`=0 has no effect.
- Reset mid-operation (any state) aborts immediately: partial outputs are discarded and the delay line is cleared. After `rst` deasserts, the first clock edge sees IDLE.

## Structure
- Shared package `fir_interp_pkg`:
  - FSM state enum `{IDLE, MAC, OUT}`;
  - default `TAPS`/`L`/`SHIFT` constants;
  - coefficient array `INTERP_COEFFS[0:47]`: 16-bit signed, symmetric low-pass at cutoff fs_in/2, scaled so each phase sum ≈ 256.
- One natural sub-module: `fir_interp_coef_rom`. Combinational lookup of `h[j*L+phase]` from the package array.
- The FSM, MAC and delay line stay in `fir_interpolator`.

## Test plan
- Reset: assert `rst` mid-stream → `m_valid`=0, `m_data`=0 and `s_ready`=1 immediately, with no clock edge required.
- Impulse with `m_ready`=1: drive `s_data`=256, then `P`+ zero inputs. Output k (0..47) must equal `INTERP_COEFFS[k]` in order, and `m_valid` must first rise 12 cycles after acceptance.
- DC: constant input 256 for ≥12 inputs → steady phase-p output = `sum_j INTERP_COEFFS[4j+p]`; the same 4-value pattern must repeat for every later input.
- Backpressure: hold `m_ready`=0 for 10 cycles in OUT → `m_valid`=1, `m_data` constant and `s_ready`=0 throughout. After release, the next phase appears 13 cycles later.
- Sign and floor: load `INTERP_COEFFS[0]`=1 into a test ROM.
  - impulse −1 → phase-0 output = −1 (floor, not 0);
  - impulse −256 → phase 0 = −1.
- Reset during MAC of phase 2 → after release, the impulse test reproduces outputs bit-identical to the clean run.
